// File: rtl/alu_issue_ctrl_if.sv
// Issue/result handshake and ALU drive bundle between decode, the issue controller and the 64-bit ALU.
interface alu_issue_ctrl_if #(
   parameter int unsigned DATA_W = 64
);
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       instr;
   logic [DATA_W-1:0] opnd_a;
   logic [DATA_W-1:0] opnd_b;
   logic [3:0]        alu_op;
   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   logic [5:0]        alu_shamt;
   logic [DATA_W-1:0] alu_out;
   logic              alu_zero;
   logic              alu_ovf;
   logic              res_valid;
   logic              res_ready;
   logic [DATA_W-1:0] res_data;
   logic              res_err;
   logic              flag_n;
   logic              flag_z;
   logic              flag_v;

   modport slave (
      input  in_valid, instr, opnd_a, opnd_b, alu_out, alu_zero, alu_ovf, res_ready,
      output in_ready, alu_op, alu_a, alu_b, alu_shamt, res_valid, res_data, res_err,
             flag_n, flag_z, flag_v
   );

   modport master (
      output in_valid, instr, opnd_a, opnd_b, alu_out, alu_zero, alu_ovf, res_ready,
      input  in_ready, alu_op, alu_a, alu_b, alu_shamt, res_valid, res_data, res_err,
             flag_n, flag_z, flag_v
   );
endinterface

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: decodes a LEGv8 instruction, holds ALU inputs for a settle window,
// captures the result and returns it over a valid/ready handshake while tracking N/Z/V.
module alu_issue_ctrl #(
   parameter int unsigned DATA_W     = 64,
   parameter int unsigned SETTLE_CYC = 1
) (
   input logic             clk,
   input logic             rst_n,
   alu_issue_ctrl_if.slave bus
);

   localparam int unsigned CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

   localparam logic [10:0] OPC_ADD  = 11'b10001011000;
   localparam logic [10:0] OPC_ADDS = 11'b10101011000;
   localparam logic [10:0] OPC_SUB  = 11'b11001011000;
   localparam logic [10:0] OPC_SUBS = 11'b11101011000;
   localparam logic [10:0] OPC_AND  = 11'b10001010000;
   localparam logic [10:0] OPC_ORR  = 11'b10101010000;
   localparam logic [10:0] OPC_EOR  = 11'b11001010000;
   localparam logic [10:0] OPC_LSL  = 11'b11010011011;
   localparam logic [10:0] OPC_LSR  = 11'b11010011010;
   localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
   localparam logic [9:0]  OPC_SUBI = 10'b1101000100;
   localparam logic [8:0]  OPC_MOVZ = 9'b110100101;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SLL = 4'b0011;
   localparam logic [3:0] ALU_XOR = 4'b0100;
   localparam logic [3:0] ALU_SRL = 4'b0101;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_LUI = 4'b0111;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2,
      HOLD    = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [3:0]        alu_op_q, alu_op_d;
   logic [DATA_W-1:0] alu_a_q, alu_a_d;
   logic [DATA_W-1:0] alu_b_q, alu_b_d;
   logic [5:0]        alu_shamt_q, alu_shamt_d;
   logic              err_q, err_d;
   logic              set_flags_q, set_flags_d;
   logic [DATA_W-1:0] res_data_q, res_data_d;
   logic              res_err_q, res_err_d;
   logic              flag_n_q, flag_n_d;
   logic              flag_z_q, flag_z_d;
   logic              flag_v_q, flag_v_d;
   logic              in_ready_q, in_ready_d;
   logic              res_valid_q, res_valid_d;

   logic [3:0]        dec_op;
   logic [DATA_W-1:0] dec_a;
   logic [DATA_W-1:0] dec_b;
   logic [5:0]        dec_shamt;
   logic              dec_err;
   logic              dec_set_flags;
   logic [10:0]       opc11;
   logic [9:0]        opc10;
   logic [8:0]        opc9;

   // Instruction decode; an unrecognised opcode leaves op/A/B at zero and marks the error.
   always_comb begin
      dec_op        = ALU_AND;
      dec_a         = '0;
      dec_b         = '0;
      dec_shamt     = '0;
      dec_err       = 1'b0;
      dec_set_flags = 1'b0;
      opc11         = bus.instr[31:21];
      opc10         = bus.instr[31:22];
      opc9          = bus.instr[31:23];
      if (opc11 == OPC_ADD || opc11 == OPC_ADDS) begin
         dec_op        = ALU_ADD;
         dec_a         = bus.opnd_a;
         dec_b         = bus.opnd_b;
         dec_set_flags = (opc11 == OPC_ADDS);
      end else if (opc11 == OPC_SUB || opc11 == OPC_SUBS) begin
         dec_op        = ALU_SUB;
         dec_a         = bus.opnd_a;
         dec_b         = bus.opnd_b;
         dec_set_flags = (opc11 == OPC_SUBS);
      end else if (opc11 == OPC_AND || opc11 == OPC_ORR || opc11 == OPC_EOR) begin
         dec_op = (opc11 == OPC_AND) ? ALU_AND : ((opc11 == OPC_ORR) ? ALU_OR : ALU_XOR);
         dec_a  = bus.opnd_a;
         dec_b  = bus.opnd_b;
      end else if (opc11 == OPC_LSL || opc11 == OPC_LSR) begin
         // The ALU shifts its B input, so the Rn value is steered onto B.
         dec_op    = (opc11 == OPC_LSL) ? ALU_SLL : ALU_SRL;
         dec_b     = bus.opnd_a;
         dec_shamt = bus.instr[15:10];
      end else if (opc10 == OPC_ADDI || opc10 == OPC_SUBI) begin
         dec_op = (opc10 == OPC_ADDI) ? ALU_ADD : ALU_SUB;
         dec_a  = bus.opnd_a;
         dec_b  = DATA_W'(bus.instr[21:10]);
      end else if (opc9 == OPC_MOVZ) begin
         dec_op = ALU_LUI;
         dec_b  = DATA_W'(bus.instr[20:5]) << {bus.instr[22:21], 4'b0000};
      end else begin
         dec_err = 1'b1;
      end
   end

   // Next-state and register updates.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      alu_op_d    = alu_op_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_shamt_d = alu_shamt_q;
      err_d       = err_q;
      set_flags_d = set_flags_q;
      res_data_d  = res_data_q;
      res_err_d   = res_err_q;
      flag_n_d    = flag_n_q;
      flag_z_d    = flag_z_q;
      flag_v_d    = flag_v_q;
      unique case (state_q)
         IDLE: begin
            if (bus.in_valid && in_ready_q) begin
               alu_op_d    = dec_op;
               alu_a_d     = dec_a;
               alu_b_d     = dec_b;
               alu_shamt_d = dec_shamt;
               err_d       = dec_err;
               set_flags_d = dec_set_flags;
               cnt_d       = '0;
               state_d     = ISSUE;
            end
         end
         ISSUE: begin
            if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
               state_d = CAPTURE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         CAPTURE: begin
            res_data_d = err_q ? '0 : bus.alu_out;
            res_err_d  = err_q;
            if (set_flags_q && !err_q) begin
               flag_n_d = bus.alu_out[DATA_W-1];
               flag_z_d = bus.alu_zero;
               flag_v_d = bus.alu_ovf;
            end
            state_d = HOLD;
         end
         HOLD: begin
            if (bus.res_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      in_ready_d  = (state_d == IDLE);
      res_valid_d = (state_d == HOLD);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         alu_op_q    <= '0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_shamt_q <= '0;
         err_q       <= 1'b0;
         set_flags_q <= 1'b0;
         res_data_q  <= '0;
         res_err_q   <= 1'b0;
         flag_n_q    <= 1'b0;
         flag_z_q    <= 1'b0;
         flag_v_q    <= 1'b0;
         in_ready_q  <= 1'b1;
         res_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         alu_op_q    <= alu_op_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_shamt_q <= alu_shamt_d;
         err_q       <= err_d;
         set_flags_q <= set_flags_d;
         res_data_q  <= res_data_d;
         res_err_q   <= res_err_d;
         flag_n_q    <= flag_n_d;
         flag_z_q    <= flag_z_d;
         flag_v_q    <= flag_v_d;
         in_ready_q  <= in_ready_d;
         res_valid_q <= res_valid_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.alu_op    = alu_op_q;
   assign bus.alu_a     = alu_a_q;
   assign bus.alu_b     = alu_b_q;
   assign bus.alu_shamt = alu_shamt_q;
   assign bus.res_valid = res_valid_q;
   assign bus.res_data  = res_data_q;
   assign bus.res_err   = res_err_q;
   assign bus.flag_n    = flag_n_q;
   assign bus.flag_z    = flag_z_q;
   assign bus.flag_v    = flag_v_q;

endmodule
